// File: rtl/if_btb_stage_pkg.sv
// Shared definitions for the IF stage with branch target buffer:
// reset fetch address, 2-bit counter encodings and the NOP word.
package if_btb_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP              = 32'h0000_0000;

  typedef enum logic [1:0] {
    CNT_SNT = 2'b00,
    CNT_WNT = 2'b01,
    CNT_WT  = 2'b10,
    CNT_ST  = 2'b11
  } cnt_e;

  // Saturating step of the 2-bit direction counter.
  function automatic cnt_e cnt_next(input cnt_e cur, input logic taken);
    cnt_e nxt;
    case (cur)
      CNT_SNT: nxt = taken ? CNT_WNT : CNT_SNT;
      CNT_WNT: nxt = taken ? CNT_WT  : CNT_SNT;
      CNT_WT:  nxt = taken ? CNT_ST  : CNT_WNT;
      CNT_ST:  nxt = taken ? CNT_ST  : CNT_WT;
      default: nxt = CNT_SNT;
    endcase
    return nxt;
  endfunction

  function automatic logic cnt_is_taken(input cnt_e cur);
    return (cur == CNT_WT) || (cur == CNT_ST);
  endfunction

endpackage

// File: rtl/if_btb_stage_btb_table.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch PC,
// clocked update from the resolved branch in EX.
module btb_table
  import if_btb_stage_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_lookup_pc,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic [31:0] i_upd_target,
  input  logic        i_upd_taken
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];
  cnt_e             r_cnt    [ENTRIES];

  logic [IDX_W-1:0] w_lk_idx;
  logic [TAG_W-1:0] w_lk_tag;
  logic             w_lk_hit;
  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_upd_hit;
  logic             w_unused_bits;

  assign w_lk_idx  = i_lookup_pc[IDX_W+1:2];
  assign w_lk_tag  = i_lookup_pc[31:IDX_W+2];
  assign w_upd_idx = i_upd_pc[IDX_W+1:2];
  assign w_upd_tag = i_upd_pc[31:IDX_W+2];
  // Fetch and branch addresses are word aligned.
  assign w_unused_bits = ^{i_lookup_pc[1:0], i_upd_pc[1:0]};

  assign w_lk_hit  = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  // Lookup reads the stored state, so a same-cycle update is not visible.
  always_comb begin
    o_pred_taken  = 1'b0;
    o_pred_target = 32'h0000_0000;
    if (w_lk_hit && cnt_is_taken(r_cnt[w_lk_idx])) begin
      o_pred_taken  = 1'b1;
      o_pred_target = r_target[w_lk_idx];
    end else begin
      o_pred_taken  = 1'b0;
      o_pred_target = 32'h0000_0000;
    end
  end

  // Table update: train on hit, allocate on taken miss, ignore not-taken miss.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= 32'h0000_0000;
        r_cnt[i]    <= CNT_SNT;
      end
    end else if (i_upd_valid) begin
      if (w_upd_hit) begin
        r_cnt[w_upd_idx] <= cnt_next(r_cnt[w_upd_idx], i_upd_taken);
        if (i_upd_taken) begin
          r_target[w_upd_idx] <= i_upd_target;
        end
      end else if (i_upd_taken) begin
        r_valid[w_upd_idx]  <= 1'b1;
        r_tag[w_upd_idx]    <= w_upd_tag;
        r_target[w_upd_idx] <= i_upd_target;
        r_cnt[w_upd_idx]    <= CNT_WT;
      end
    end
  end

endmodule

// File: rtl/if_btb_stage.sv
// Instruction fetch stage: PC register, next-PC selection with BTB
// prediction, and the IF/ID pipeline registers.
module if_btb_stage
  import if_btb_stage_pkg::*;
#(
  parameter int          ENTRIES  = 16,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_mispredict,
  input  logic [31:0] i_correct_pc,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic [31:0] i_upd_target,
  input  logic        i_upd_taken,
  input  logic [31:0] i_instruction,
  output logic [31:0] o_pc,
  output logic [31:0] o_if_id_instruction,
  output logic [31:0] o_if_id_pcplus4,
  output logic        o_if_id_pred_taken,
  output logic [31:0] o_if_id_pred_target
);

  logic [31:0] r_pc;
  logic [31:0] r_if_id_instruction;
  logic [31:0] r_if_id_pcplus4;
  logic        r_if_id_pred_taken;
  logic [31:0] r_if_id_pred_target;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;
  logic        w_pred_taken;
  logic [31:0] w_pred_target;

  btb_table #(
    .ENTRIES(ENTRIES)
  ) u_btb (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_lookup_pc  (r_pc),
    .o_pred_taken (w_pred_taken),
    .o_pred_target(w_pred_target),
    .i_upd_valid  (i_upd_valid),
    .i_upd_pc     (i_upd_pc),
    .i_upd_target (i_upd_target),
    .i_upd_taken  (i_upd_taken)
  );

  assign w_pc_plus4 = r_pc + 32'd4;

  // Redirect beats stall, stall beats prediction, prediction beats sequential.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (i_mispredict) begin
      w_next_pc = i_correct_pc;
    end else if (i_stall) begin
      w_next_pc = r_pc;
    end else if (w_pred_taken) begin
      w_next_pc = w_pred_target;
    end else begin
      w_next_pc = w_pc_plus4;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_next_pc;
    end
  end

  // IF/ID: bubble on redirect, hold on stall, otherwise capture this fetch.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_if_id_instruction <= NOP;
      r_if_id_pcplus4     <= 32'h0000_0000;
      r_if_id_pred_taken  <= 1'b0;
      r_if_id_pred_target <= 32'h0000_0000;
    end else if (i_mispredict) begin
      r_if_id_instruction <= NOP;
      r_if_id_pcplus4     <= 32'h0000_0000;
      r_if_id_pred_taken  <= 1'b0;
      r_if_id_pred_target <= 32'h0000_0000;
    end else if (!i_stall) begin
      r_if_id_instruction <= i_instruction;
      r_if_id_pcplus4     <= w_pc_plus4;
      r_if_id_pred_taken  <= w_pred_taken;
      r_if_id_pred_target <= w_pred_target;
    end
  end

  assign o_pc                = r_pc;
  assign o_if_id_instruction = r_if_id_instruction;
  assign o_if_id_pcplus4     = r_if_id_pcplus4;
  assign o_if_id_pred_taken  = r_if_id_pred_taken;
  assign o_if_id_pred_target = r_if_id_pred_target;

endmodule

// File: tb/tb_if_btb_stage.sv
// Directed self-checking bench for if_btb_stage (ENTRIES=16, RESET_PC=0).
module tb_if_btb_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        mispredict;
  logic [31:0] correct_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pcp4;
  logic        ifid_pt;
  logic [31:0] ifid_ptgt;

  int n_cmp = 0;
  int n_bad = 0;

  if_btb_stage #(
    .ENTRIES (16),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_stall            (stall),
    .i_mispredict       (mispredict),
    .i_correct_pc       (correct_pc),
    .i_upd_valid        (upd_valid),
    .i_upd_pc           (upd_pc),
    .i_upd_target       (upd_target),
    .i_upd_taken        (upd_taken),
    .i_instruction      (instr),
    .o_pc               (pc),
    .o_if_id_instruction(ifid_instr),
    .o_if_id_pcplus4    (ifid_pcp4),
    .o_if_id_pred_taken (ifid_pt),
    .o_if_id_pred_target(ifid_ptgt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic btb_update(input logic [31:0] a, input logic [31:0] t, input logic tk);
    upd_valid = 1'b1; upd_pc = a; upd_target = t; upd_taken = tk;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic redirect_fetch(input logic [31:0] a, input logic [31:0] ins);
    mispredict = 1'b1; correct_pc = a;
    tick();
    mispredict = 1'b0; instr = ins;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; mispredict = 1'b0; correct_pc = 32'h0;
    upd_valid = 1'b0; upd_pc = 32'h0; upd_target = 32'h0; upd_taken = 1'b0;
    instr = 32'h0;
    tick(); tick();
    n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want %h", pc, 32'h0); end
    n_cmp++; if (ifid_instr !== 32'h0) begin n_bad++; $display("FAIL reset_instr: got %h want %h", ifid_instr, 32'h0); end
    n_cmp++; if (ifid_pcp4 !== 32'h0) begin n_bad++; $display("FAIL reset_pcp4: got %h want %h", ifid_pcp4, 32'h0); end
    n_cmp++; if (ifid_pt !== 1'b0) begin n_bad++; $display("FAIL reset_pt: got %b want 0", ifid_pt); end
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    instr = 32'h0;
    n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL free_pc0: got %h want %h", pc, 32'h0); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_cmp++; if (pc !== 32'(4 * k)) begin n_bad++; $display("FAIL free_pc%0d: got %h want %h", k, pc, 32'(4 * k)); end
      n_cmp++; if (ifid_pcp4 !== 32'(4 * k)) begin n_bad++; $display("FAIL free_pcp4_%0d: got %h want %h", k, ifid_pcp4, 32'(4 * k)); end
      n_cmp++; if (ifid_pt !== 1'b0) begin n_bad++; $display("FAIL free_pt%0d: got %b want 0", k, ifid_pt); end
    end
  endtask

  task automatic test_btb_taken();
    mispredict = 1'b1; correct_pc = 32'h40;
    tick();
    mispredict = 1'b0;
    n_cmp++; if (pc !== 32'h40) begin n_bad++; $display("FAIL redir_pc: got %h want %h", pc, 32'h40); end
    n_cmp++; if (ifid_pcp4 !== 32'h0) begin n_bad++; $display("FAIL redir_bubble: got %h want %h", ifid_pcp4, 32'h0); end
    // Update and lookup of the same entry in one cycle: lookup sees the old miss.
    instr = 32'h1111_1111;
    btb_update(32'h40, 32'h100, 1'b1);
    n_cmp++; if (pc !== 32'h44) begin n_bad++; $display("FAIL same_cycle_pc: got %h want %h", pc, 32'h44); end
    n_cmp++; if (ifid_pt !== 1'b0) begin n_bad++; $display("FAIL same_cycle_pt: got %b want 0", ifid_pt); end
    n_cmp++; if (ifid_ptgt !== 32'h0) begin n_bad++; $display("FAIL same_cycle_ptgt: got %h want %h", ifid_ptgt, 32'h0); end
    n_cmp++; if (ifid_instr !== 32'h1111_1111) begin n_bad++; $display("FAIL same_cycle_instr: got %h want %h", ifid_instr, 32'h1111_1111); end
    redirect_fetch(32'h40, 32'hDEAD_BEEF);
    n_cmp++; if (pc !== 32'h100) begin n_bad++; $display("FAIL taken_pc: got %h want %h", pc, 32'h100); end
    n_cmp++; if (ifid_pt !== 1'b1) begin n_bad++; $display("FAIL taken_pt: got %b want 1", ifid_pt); end
    n_cmp++; if (ifid_ptgt !== 32'h100) begin n_bad++; $display("FAIL taken_ptgt: got %h want %h", ifid_ptgt, 32'h100); end
    n_cmp++; if (ifid_pcp4 !== 32'h44) begin n_bad++; $display("FAIL taken_pcp4: got %h want %h", ifid_pcp4, 32'h44); end
    n_cmp++; if (ifid_instr !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL taken_instr: got %h want %h", ifid_instr, 32'hDEAD_BEEF); end
  endtask

  task automatic test_not_taken();
    btb_update(32'h40, 32'h0, 1'b0);
    btb_update(32'h40, 32'h0, 1'b0);
    redirect_fetch(32'h40, 32'h0);
    n_cmp++; if (pc !== 32'h44) begin n_bad++; $display("FAIL nt2_pc: got %h want %h", pc, 32'h44); end
    n_cmp++; if (ifid_pt !== 1'b0) begin n_bad++; $display("FAIL nt2_pt: got %b want 0", ifid_pt); end
    // Third not-taken must stay at 0; one taken then gives WNT, still no prediction.
    btb_update(32'h40, 32'h0, 1'b0);
    btb_update(32'h40, 32'h100, 1'b1);
    redirect_fetch(32'h40, 32'h0);
    n_cmp++; if (pc !== 32'h44) begin n_bad++; $display("FAIL nt_sat_pc: got %h want %h", pc, 32'h44); end
    btb_update(32'h40, 32'h100, 1'b1);
    redirect_fetch(32'h40, 32'h0);
    n_cmp++; if (pc !== 32'h100) begin n_bad++; $display("FAIL retrain_pc: got %h want %h", pc, 32'h100); end
    n_cmp++; if (ifid_pt !== 1'b1) begin n_bad++; $display("FAIL retrain_pt: got %b want 1", ifid_pt); end
  endtask

  task automatic test_stall();
    redirect_fetch(32'h1C, 32'hAAAA_0001);
    n_cmp++; if (pc !== 32'h20) begin n_bad++; $display("FAIL pre_stall_pc: got %h want %h", pc, 32'h20); end
    stall = 1'b1; instr = 32'hBBBB_0002;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (pc !== 32'h20) begin n_bad++; $display("FAIL stall_pc%0d: got %h want %h", k, pc, 32'h20); end
      n_cmp++; if (ifid_instr !== 32'hAAAA_0001) begin n_bad++; $display("FAIL stall_instr%0d: got %h want %h", k, ifid_instr, 32'hAAAA_0001); end
      n_cmp++; if (ifid_pcp4 !== 32'h20) begin n_bad++; $display("FAIL stall_pcp4%0d: got %h want %h", k, ifid_pcp4, 32'h20); end
    end
    mispredict = 1'b1; correct_pc = 32'h200;
    tick();
    mispredict = 1'b0; stall = 1'b0;
    n_cmp++; if (pc !== 32'h200) begin n_bad++; $display("FAIL stall_mp_pc: got %h want %h", pc, 32'h200); end
    n_cmp++; if (ifid_instr !== 32'h0) begin n_bad++; $display("FAIL stall_mp_instr: got %h want %h", ifid_instr, 32'h0); end
    n_cmp++; if (ifid_pcp4 !== 32'h0) begin n_bad++; $display("FAIL stall_mp_pcp4: got %h want %h", ifid_pcp4, 32'h0); end
  endtask

  task automatic test_alias();
    btb_update(32'h40, 32'h100, 1'b1);
    btb_update(32'h80, 32'h300, 1'b1);
    redirect_fetch(32'h40, 32'h0);
    n_cmp++; if (pc !== 32'h44) begin n_bad++; $display("FAIL alias_old_pc: got %h want %h", pc, 32'h44); end
    n_cmp++; if (ifid_pt !== 1'b0) begin n_bad++; $display("FAIL alias_old_pt: got %b want 0", ifid_pt); end
    redirect_fetch(32'h80, 32'h0);
    n_cmp++; if (pc !== 32'h300) begin n_bad++; $display("FAIL alias_new_pc: got %h want %h", pc, 32'h300); end
    n_cmp++; if (ifid_ptgt !== 32'h300) begin n_bad++; $display("FAIL alias_new_ptgt: got %h want %h", ifid_ptgt, 32'h300); end
  endtask

  task automatic test_async_reset();
    n_cmp++; if (ifid_pt !== 1'b1) begin n_bad++; $display("FAIL pre_rst_pt: got %b want 1", ifid_pt); end
    upd_valid = 1'b1; upd_pc = 32'h0; upd_target = 32'h500; upd_taken = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL arst_pc: got %h want %h", pc, 32'h0); end
    n_cmp++; if (ifid_pt !== 1'b0) begin n_bad++; $display("FAIL arst_pt: got %b want 0", ifid_pt); end
    n_cmp++; if (ifid_ptgt !== 32'h0) begin n_bad++; $display("FAIL arst_ptgt: got %h want %h", ifid_ptgt, 32'h0); end
    n_cmp++; if (ifid_pcp4 !== 32'h0) begin n_bad++; $display("FAIL arst_pcp4: got %h want %h", ifid_pcp4, 32'h0); end
    tick();
    rst = 1'b0; upd_valid = 1'b0; instr = 32'h0;
    n_cmp++; if (pc !== 32'h0) begin n_bad++; $display("FAIL post_rst_pc: got %h want %h", pc, 32'h0); end
    tick();
    n_cmp++; if (pc !== 32'h4) begin n_bad++; $display("FAIL aborted_upd_pc: got %h want %h", pc, 32'h4); end
    redirect_fetch(32'h80, 32'h0);
    n_cmp++; if (pc !== 32'h84) begin n_bad++; $display("FAIL hit_gone_pc: got %h want %h", pc, 32'h84); end
    n_cmp++; if (ifid_pt !== 1'b0) begin n_bad++; $display("FAIL hit_gone_pt: got %b want 0", ifid_pt); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_btb_taken();
    test_not_taken();
    test_stall();
    test_alias();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
